// File: rtl/multi_angle_ctrl_pkg.sv
// Shared types and constants for the steering-angle controller.
package multi_angle_ctrl_pkg;
  localparam int PWM_W = 8;

  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_RUN      = 2'd1,
    CH_WAIT_PWM = 2'd2
  } ch_state_e;

  typedef enum logic {
    STG_SEL   = 1'b0,
    STG_APPLY = 1'b1
  } stage_e;
endpackage

// File: rtl/multi_angle_ctrl_if.sv
// PWM generator handshake bundle: ratio/direction/update out, done back.
interface multi_angle_ctrl_if
  import multi_angle_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4
) ();
  logic [NUM_CH-1:0]            pwm_enable;
  logic [NUM_CH-1:0][PWM_W-1:0] pwm_ratio;
  logic [NUM_CH-1:0]            pwm_direction;
  logic [NUM_CH-1:0]            pwm_update;
  logic [NUM_CH-1:0]            pwm_done;

  modport master (output pwm_enable, pwm_ratio, pwm_direction, pwm_update, input pwm_done);
  modport slave  (input pwm_enable, pwm_ratio, pwm_direction, pwm_update, output pwm_done);
endinterface

// File: rtl/angle_sample_sync.sv
// Per-channel encoder capture: 2-flop sync, rising-edge detect, angle register, pending flag.
module angle_sample_sync #(
  parameter int ANGLE_W = 12
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enc_rd_done,
  input  logic [ANGLE_W-1:0] enc_angle,
  input  logic               clear,
  output logic [ANGLE_W-1:0] angle,
  output logic               pending
);
  // [0],[1] synchroniser, [2] previous value for edge detect
  logic [2:0] sync_q;
  logic       rise;

  assign rise = sync_q[1] & ~sync_q[2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      angle   <= '0;
      pending <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], enc_rd_done};
      // a fresh edge outranks the grant clear so the newest sample is never lost
      if (rise) begin
        angle   <= enc_angle;
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/multi_angle_ctrl.sv
// N-channel steering controller: shortest-path error, P-law with clamp, stall check, shared RR compute slot.
module multi_angle_ctrl
  import multi_angle_ctrl_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int ANGLE_W       = 12,
  parameter int DIV_W         = 7,
  parameter int DEADBAND      = 8,
  parameter int KP_SHIFT      = 2,
  parameter int MIN_POWER     = 20,
  parameter int MAX_POWER     = 200,
  parameter int STALL_SAMPLES = 4
) (
  input  logic                            clock,
  input  logic                            reset_n,
  output logic                            enc_clk,
  input  logic [NUM_CH-1:0][ANGLE_W-1:0]  enc_angle,
  input  logic [NUM_CH-1:0]               enc_rd_done,
  input  logic [NUM_CH-1:0][ANGLE_W-1:0]  target_angle,
  input  logic [NUM_CH-1:0]               angle_update,
  input  logic [NUM_CH-1:0]               abort_angle,
  output logic [NUM_CH-1:0][ANGLE_W-1:0]  current_angle,
  output logic [NUM_CH-1:0]               angle_done,
  output logic [NUM_CH-1:0]               stall_fail,
  output logic                            busy,
  multi_angle_ctrl_if.master              pwm
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(STALL_SAMPLES + 1);

  logic [DIV_W-1:0]                 div_q;
  logic [NUM_CH-1:0]                pending, req, grant_clr, apply_hit;
  ch_state_e [NUM_CH-1:0]           state_q, state_d;
  stage_e                           stage_q;
  logic [CH_W-1:0]                  gnt_q, sel_idx;
  logic                             sel_vld;
  logic [NUM_CH-1:0][ANGLE_W-1:0]   target_q, prev_q;
  logic [NUM_CH-1:0][CNT_W-1:0]     stall_cnt_q;
  logic [ANGLE_W-1:0]               err, mag;
  logic [ANGLE_W:0]                 pw;
  logic [PWM_W-1:0]                 ratio_c;
  logic [CNT_W-1:0]                 cnt_inc;
  logic                             neg, in_db, same, stall_c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= div_q + 1'b1;
  end
  assign enc_clk = div_q[DIV_W-1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    angle_sample_sync #(.ANGLE_W(ANGLE_W)) u_sync (
      .clock       (clock),
      .reset_n     (reset_n),
      .enc_rd_done (enc_rd_done[i]),
      .enc_angle   (enc_angle[i]),
      .clear       (grant_clr[i]),
      .angle       (current_angle[i]),
      .pending     (pending[i])
    );
    assign req[i] = (state_q[i] == CH_RUN) && pending[i];
  end

  // round-robin search starts just after the last granted channel
  always_comb begin
    int idx;
    sel_vld = 1'b0;
    sel_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(gnt_q) + k) % NUM_CH;
      if (!sel_vld && req[idx]) begin
        sel_vld = 1'b1;
        sel_idx = CH_W'(idx);
      end
    end
    grant_clr = '0;
    if (stage_q == STG_SEL && sel_vld) grant_clr[sel_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= STG_SEL;
      gnt_q   <= CH_W'(NUM_CH - 1);
    end else if (stage_q == STG_SEL) begin
      if (sel_vld) begin
        gnt_q   <= sel_idx;
        stage_q <= STG_APPLY;
      end
    end else begin
      stage_q <= STG_SEL;
    end
  end

  // shared datapath for the granted channel; -2^(W-1) counts as positive
  always_comb begin
    err     = target_q[gnt_q] - current_angle[gnt_q];
    neg     = err[ANGLE_W-1] & (|err[ANGLE_W-2:0]);
    mag     = neg ? (~err + 1'b1) : err;
    in_db   = mag <= ANGLE_W'(DEADBAND);
    pw      = (ANGLE_W+1)'(MIN_POWER) + {1'b0, mag >> KP_SHIFT};
    ratio_c = (pw > (ANGLE_W+1)'(MAX_POWER)) ? PWM_W'(MAX_POWER) : pw[PWM_W-1:0];
    same    = current_angle[gnt_q] == prev_q[gnt_q];
    cnt_inc = stall_cnt_q[gnt_q] + 1'b1;
    stall_c = same && (cnt_inc >= CNT_W'(STALL_SAMPLES));
  end

  always_comb begin
    state_d   = state_q;
    apply_hit = '0;
    busy      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      apply_hit[i] = (stage_q == STG_APPLY) && (gnt_q == CH_W'(i)) &&
                     (state_q[i] == CH_RUN) && !abort_angle[i];
      if (abort_angle[i]) state_d[i] = CH_IDLE;
      else begin
        case (state_q[i])
          CH_IDLE:     if (angle_update[i]) state_d[i] = CH_RUN;
          CH_RUN:      if (apply_hit[i]) state_d[i] = (in_db || stall_c) ? CH_IDLE : CH_WAIT_PWM;
          CH_WAIT_PWM: if (pwm.pwm_done[i]) state_d[i] = CH_RUN;
          default:     state_d[i] = CH_IDLE;
        endcase
      end
      busy = busy | (state_q[i] != CH_IDLE);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) state_q[i] <= CH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      target_q          <= '0;
      prev_q            <= '0;
      stall_cnt_q       <= '0;
      angle_done        <= '0;
      stall_fail        <= '0;
      pwm.pwm_enable    <= '0;
      pwm.pwm_ratio     <= '0;
      pwm.pwm_direction <= '0;
      pwm.pwm_update    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm.pwm_update[i] <= apply_hit[i] && !in_db && !stall_c;
        if (abort_angle[i]) begin
          pwm.pwm_enable[i] <= 1'b0;
        end else if (apply_hit[i]) begin
          prev_q[i]      <= current_angle[i];
          stall_cnt_q[i] <= same ? cnt_inc : '0;
          if (in_db) begin
            pwm.pwm_enable[i] <= 1'b0;
            angle_done[i]     <= 1'b1;
          end else if (stall_c) begin
            pwm.pwm_enable[i] <= 1'b0;
            stall_fail[i]     <= 1'b1;
          end else begin
            pwm.pwm_enable[i]    <= 1'b1;
            pwm.pwm_ratio[i]     <= ratio_c;
            pwm.pwm_direction[i] <= ~neg;
          end
        end
        // re-target also restarts the stall count; status flags clear only on a fresh move
        if (angle_update[i] && !abort_angle[i]) begin
          target_q[i]    <= target_angle[i];
          stall_cnt_q[i] <= '0;
          if (state_q[i] == CH_IDLE) begin
            angle_done[i] <= 1'b0;
            stall_fail[i] <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_angle_ctrl.sv
// Directed bench for multi_angle_ctrl; expected PWM updates go through a scoreboard queue.
module tb_multi_angle_ctrl;
  typedef struct {
    int ch;
    int ratio;
    int dir;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enc_clk;
  logic [3:0][11:0] enc_angle, target_angle, current_angle;
  logic [3:0]       enc_rd_done, angle_update, abort_angle, angle_done, stall_fail;
  logic             busy;
  logic [3:0]       auto_ack, late_done, prev_upd;
  int               ack_cd [4];
  int               upd_cyc [4];
  int               cycle = 0;
  int               total = 0;
  int               bad = 0;
  exp_t             q[$];

  multi_angle_ctrl_if #(.NUM_CH(4)) pif ();

  multi_angle_ctrl dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enc_clk       (enc_clk),
    .enc_angle     (enc_angle),
    .enc_rd_done   (enc_rd_done),
    .target_angle  (target_angle),
    .angle_update  (angle_update),
    .abort_angle   (abort_angle),
    .current_angle (current_angle),
    .angle_done    (angle_done),
    .stall_fail    (stall_fail),
    .busy          (busy),
    .pwm           (pif)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input int ratio, input int dir);
    exp_t e;
    e.ch = ch; e.ratio = ratio; e.dir = dir;
    q.push_back(e);
  endtask

  task automatic pulse_rd(input logic [3:0] m);
    @(negedge clock) enc_rd_done = m;
    repeat (4) @(negedge clock);
    enc_rd_done = '0;
    repeat (14) @(negedge clock);
  endtask

  task automatic update_mask(input logic [3:0] m);
    @(negedge clock) angle_update = m;
    @(negedge clock) angle_update = '0;
  endtask

  task automatic drained(input string name);
    check(name, q.size(), 0);
  endtask

  initial forever @(posedge clock) cycle++;

  // PWM model: acknowledge each update 3 cycles later when enabled
  initial begin
    pif.pwm_done = '0;
    for (int i = 0; i < 4; i++) ack_cd[i] = 0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        logic fire;
        fire = 1'b0;
        if (ack_cd[i] > 0) begin
          ack_cd[i]--;
          fire = (ack_cd[i] == 0);
        end
        if (pif.pwm_update[i] && auto_ack[i]) ack_cd[i] = 3;
        pif.pwm_done[i] = fire | late_done[i];
      end
    end
  end

  initial begin
    exp_t e;
    prev_upd = '0;
    forever begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        if (pif.pwm_update[i]) begin
          upd_cyc[i] = cycle;
          check("upd_width", {31'd0, prev_upd[i]}, 0);
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_update: ch %0d ratio %0d, none expected", i, pif.pwm_ratio[i]);
          end else begin
            e = q.pop_front();
            check("upd_ch", i, e.ch);
            check("upd_ratio", {24'd0, pif.pwm_ratio[i]}, e.ratio);
            check("upd_dir", {31'd0, pif.pwm_direction[i]}, e.dir);
            check("upd_en", {31'd0, pif.pwm_enable[i]}, 1);
          end
        end
        prev_upd[i] = pif.pwm_update[i];
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clock);
    $display("FAIL watchdog: cycle %0d reached, limit 20000", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    enc_angle = '0; target_angle = '0; enc_rd_done = '0;
    angle_update = '0; abort_angle = '0; auto_ack = '1; late_done = '0;
    repeat (3) @(negedge clock);
    check("rst_enc_clk", {31'd0, enc_clk}, 0);
    check("rst_current", current_angle[0] | current_angle[1] | current_angle[2] | current_angle[3], 0);
    check("rst_done", angle_done, 0);
    check("rst_stall", stall_fail, 0);
    check("rst_en", pif.pwm_enable, 0);
    check("rst_upd", pif.pwm_update, 0);
    check("rst_ratio", pif.pwm_ratio, 0);
    check("rst_dir", pif.pwm_direction, 0);
    check("rst_busy", {31'd0, busy}, 0);
    reset_n = 1'b1;

    // ch0: simple move, then deadband
    target_angle[0] = 12'd100;
    update_mask(4'b0001);
    check("busy_run", {31'd0, busy}, 1);
    enc_angle[0] = 12'd0;
    push(0, 45, 1);
    pulse_rd(4'b0001);
    drained("ch0_move");
    check("ch0_en_hold", {31'd0, pif.pwm_enable[0]}, 1);
    enc_angle[0] = 12'd95;
    pulse_rd(4'b0001);
    check("db_done", {31'd0, angle_done[0]}, 1);
    check("db_en", {31'd0, pif.pwm_enable[0]}, 0);

    // ch1: wrap-around with latency checks, then reverse wrap
    target_angle[1] = 12'd10;
    update_mask(4'b0010);
    enc_angle[1] = 12'd4090;
    push(1, 24, 1);
    @(negedge clock) enc_rd_done[1] = 1'b1;
    repeat (2) @(posedge clock);
    #1 check("cap_early", current_angle[1], 0);
    @(posedge clock);
    #1 check("cap_3clk", current_angle[1], 4090);
    @(posedge clock);
    #1 check("upd_early", {31'd0, pif.pwm_update[1]}, 0);
    @(posedge clock);
    #1 check("upd_2clk", {31'd0, pif.pwm_update[1]}, 1);
    repeat (2) @(negedge clock);
    enc_rd_done = '0;
    repeat (12) @(negedge clock);
    drained("wrap_fwd");
    target_angle[1] = 12'd4090;
    update_mask(4'b0010);
    enc_angle[1] = 12'd10;
    push(1, 24, 0);
    pulse_rd(4'b0010);
    drained("wrap_rev");

    // ch2: encoder frozen at 0 -> stall on the 4th sample
    target_angle[2] = 12'd500;
    update_mask(4'b0100);
    enc_angle[2] = 12'd0;
    repeat (3) push(2, 145, 1);
    repeat (4) pulse_rd(4'b0100);
    drained("stall_upd");
    check("stall_fail", {31'd0, stall_fail[2]}, 1);
    check("stall_en", {31'd0, pif.pwm_enable[2]}, 0);
    update_mask(4'b0100);
    check("stall_clr", {31'd0, stall_fail[2]}, 0);
    @(negedge clock) abort_angle = 4'b0100;
    @(negedge clock) abort_angle = '0;

    // ch3: half-turn saturates at MAX_POWER
    target_angle[3] = 12'd2048;
    update_mask(4'b1000);
    enc_angle[3] = 12'd0;
    push(3, 200, 1);
    pulse_rd(4'b1000);
    drained("half_turn");

    // all channels sample together: serviced ch0..ch3, 2 cycles apart
    target_angle = {12'd1000, 12'd40, 12'd3896, 12'd400};
    update_mask(4'hF);
    enc_angle = '0;
    push(0, 120, 1); push(1, 70, 0); push(2, 30, 1); push(3, 200, 1);
    pulse_rd(4'hF);
    repeat (6) @(negedge clock);
    drained("rr_all");
    for (int i = 0; i < 3; i++) check("rr_gap", upd_cyc[i+1] - upd_cyc[i], 2);

    // abort in WAIT_PWM, late done ignored, channel parked in IDLE
    auto_ack[0] = 1'b0;
    enc_angle[0] = 12'd50;
    push(0, 107, 1);
    pulse_rd(4'b0001);
    drained("abort_pre");
    check("abort_en_pre", {31'd0, pif.pwm_enable[0]}, 1);
    @(negedge clock) abort_angle = 4'b0001;
    @(posedge clock);
    #1 check("abort_en", {31'd0, pif.pwm_enable[0]}, 0);
    @(negedge clock) abort_angle = '0; late_done[0] = 1'b1;
    @(negedge clock) late_done[0] = 1'b0;
    enc_angle[0] = 12'd200;
    pulse_rd(4'b0001);
    check("abort_en_post", {31'd0, pif.pwm_enable[0]}, 0);
    check("abort_done", {31'd0, angle_done[0]}, 0);
    drained("abort_post");

    // reset in the middle of a ch1 handshake
    enc_angle[1] = 12'd100;
    push(1, 95, 0);
    @(negedge clock) enc_rd_done[1] = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_en", pif.pwm_enable, 0);
    check("mid_rst_upd", pif.pwm_update, 0);
    check("mid_rst_ratio", pif.pwm_ratio, 0);
    check("mid_rst_dir", pif.pwm_direction, 0);
    check("mid_rst_cur", current_angle[1], 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_enc_clk", {31'd0, enc_clk}, 0);
    check("mid_rst_stall", stall_fail, 0);
    enc_rd_done = '0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    drained("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
